// File: rtl/issue_ctrl.sv
// Dual-issue dispatch stage: pairs the two oldest buffered instructions,
// registers them for execute and scoreboards long-latency destinations.
package issue_pkg;
    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  rf_raddr1;
        logic [4:0]  rf_raddr2;
        logic        rf_we;
        logic [4:0]  rf_waddr;
        logic        is_ld;
        logic        is_st;
        logic        is_muldiv;
        logic        is_br;
    } pc_set_t;
endpackage

module issue_ctrl
    import issue_pkg::*;
#(
    parameter int NREG = 32
) (
    input  logic            clk,
    input  logic            rstn,
    input  pc_set_t         i_PC_set1,
    input  pc_set_t         i_PC_set2,
    input  logic [1:0]      i_is_valid,
    input  logic            i_stall,
    input  logic            i_flush,
    input  logic            i_wb1_valid,
    input  logic [4:0]      i_wb1_waddr,
    input  logic            i_wb2_valid,
    input  logic [4:0]      i_wb2_waddr,
    output logic [1:0]      o_usingNUM,
    output pc_set_t         o_PC_set1,
    output pc_set_t         o_PC_set2,
    output logic [1:0]      o_is_valid,
    output logic [NREG-1:0] o_busy
);

    logic [NREG-1:0] busy_d;
    logic            a_blk;
    logic            b_blk;
    logic            a_go;
    logic            b_go;

    function automatic logic is_busy(input logic [4:0] r,
                                     input logic [NREG-1:0] sb);
        return (r != 5'd0) && sb[r];
    endfunction

    function automatic logic sets_busy(input pc_set_t p);
        return p.rf_we && (p.rf_waddr != 5'd0) && (p.is_ld || p.is_muldiv);
    endfunction

    always_comb begin
        a_blk = is_busy(i_PC_set1.rf_raddr1, o_busy)
              | is_busy(i_PC_set1.rf_raddr2, o_busy)
              | (i_PC_set1.rf_we & is_busy(i_PC_set1.rf_waddr, o_busy));
        a_go  = i_is_valid[1] & ~i_stall & ~i_flush & ~a_blk;

        b_blk = 1'b0;
        if (i_PC_set1.rf_we && i_PC_set1.rf_waddr != 5'd0 &&
            (i_PC_set2.rf_raddr1 == i_PC_set1.rf_waddr ||
             i_PC_set2.rf_raddr2 == i_PC_set1.rf_waddr))
            b_blk = 1'b1;
        if (i_PC_set1.rf_we && i_PC_set2.rf_we &&
            i_PC_set1.rf_waddr != 5'd0 &&
            i_PC_set1.rf_waddr == i_PC_set2.rf_waddr)
            b_blk = 1'b1;
        if ((i_PC_set1.is_ld | i_PC_set1.is_st) &&
            (i_PC_set2.is_ld | i_PC_set2.is_st))
            b_blk = 1'b1;
        if (i_PC_set1.is_muldiv && i_PC_set2.is_muldiv)
            b_blk = 1'b1;
        if (i_PC_set1.is_br)
            b_blk = 1'b1;
        if (is_busy(i_PC_set2.rf_raddr1, o_busy) ||
            is_busy(i_PC_set2.rf_raddr2, o_busy) ||
            (i_PC_set2.rf_we && is_busy(i_PC_set2.rf_waddr, o_busy)))
            b_blk = 1'b1;

        b_go       = a_go & i_is_valid[0] & ~b_blk;
        o_usingNUM = {b_go, a_go & ~b_go};
    end

    // Clears first, then sets, so a set wins on the same bit.
    always_comb begin
        busy_d = o_busy;
        if (i_wb1_valid) busy_d[i_wb1_waddr] = 1'b0;
        if (i_wb2_valid) busy_d[i_wb2_waddr] = 1'b0;
        if (i_flush) begin
            if (o_is_valid[1] && sets_busy(o_PC_set1))
                busy_d[o_PC_set1.rf_waddr] = 1'b0;
            if (o_is_valid[0] && sets_busy(o_PC_set2))
                busy_d[o_PC_set2.rf_waddr] = 1'b0;
        end
        if (a_go && sets_busy(i_PC_set1))
            busy_d[i_PC_set1.rf_waddr] = 1'b1;
        if (b_go && sets_busy(i_PC_set2))
            busy_d[i_PC_set2.rf_waddr] = 1'b1;
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            o_busy     <= '0;
            o_is_valid <= 2'b00;
            o_PC_set1  <= '0;
            o_PC_set2  <= '0;
        end else begin
            o_busy <= busy_d;
            if (i_flush) begin
                o_is_valid <= 2'b00;
            end else if (!i_stall) begin
                o_is_valid <= {a_go, b_go};
                o_PC_set1  <= i_PC_set1;
                o_PC_set2  <= i_PC_set2;
            end
        end
    end

endmodule

// File: tb/tb_issue_ctrl.sv
// Bench for issue_ctrl: directed scenarios plus random traffic
// checked against an instruction-level pairing model.
module tb_issue_ctrl;
    import issue_pkg::*;

    logic        clk = 1'b0;
    logic        rstn;
    pc_set_t     a, b;
    logic [1:0]  iv;
    logic        stall, flush;
    logic        wb1v, wb2v;
    logic [4:0]  wb1a, wb2a;
    logic [1:0]  o_usingNUM;
    pc_set_t     o_PC_set1, o_PC_set2;
    logic [1:0]  o_is_valid;
    logic [31:0] o_busy;

    int total = 0;
    int passed = 0;

    logic [31:0] m_busy;
    logic [1:0]  m_v;
    pc_set_t     m_o1, m_o2;

    always #5 clk = ~clk;

    issue_ctrl #(.NREG(32)) dut (
        .clk(clk), .rstn(rstn),
        .i_PC_set1(a), .i_PC_set2(b),
        .i_is_valid(iv), .i_stall(stall), .i_flush(flush),
        .i_wb1_valid(wb1v), .i_wb1_waddr(wb1a),
        .i_wb2_valid(wb2v), .i_wb2_waddr(wb2a),
        .o_usingNUM(o_usingNUM),
        .o_PC_set1(o_PC_set1), .o_PC_set2(o_PC_set2),
        .o_is_valid(o_is_valid), .o_busy(o_busy)
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // cls: 0 alu, 1 load, 2 store, 3 mul/div, 4 branch
    function automatic pc_set_t mk(input int cls, input int rd,
                                   input int rs1, input int rs2,
                                   input int pc);
        pc_set_t p;
        p = '0;
        p.pc        = 32'(pc);
        p.rf_raddr1 = 5'(rs1);
        p.rf_raddr2 = 5'(rs2);
        p.rf_we     = (cls == 0 || cls == 1 || cls == 3);
        p.rf_waddr  = p.rf_we ? 5'(rd) : 5'd0;
        p.is_ld     = (cls == 1);
        p.is_st     = (cls == 2);
        p.is_muldiv = (cls == 3);
        p.is_br     = (cls == 4);
        return p;
    endfunction

    function automatic bit bz(input logic [4:0] r);
        return r != 0 && m_busy[r];
    endfunction

    function automatic bit long_lat(input pc_set_t p);
        return p.rf_we && p.rf_waddr != 0 && (p.is_ld || p.is_muldiv);
    endfunction

    function automatic bit stuck(input pc_set_t p);
        return bz(p.rf_raddr1) || bz(p.rf_raddr2) ||
               (p.rf_we && bz(p.rf_waddr));
    endfunction

    function automatic int m_n();
        bit mem_a, mem_b;
        if (!iv[1] || stall || flush || stuck(a)) return 0;
        if (!iv[0] || a.is_br || stuck(b)) return 1;
        if (a.rf_we && a.rf_waddr != 0 &&
            (b.rf_raddr1 == a.rf_waddr || b.rf_raddr2 == a.rf_waddr))
            return 1;
        if (a.rf_we && b.rf_we && a.rf_waddr != 0 &&
            a.rf_waddr == b.rf_waddr) return 1;
        mem_a = a.is_ld || a.is_st;
        mem_b = b.is_ld || b.is_st;
        if (mem_a && mem_b) return 1;
        if (a.is_muldiv && b.is_muldiv) return 1;
        return 2;
    endfunction

    task automatic step(input string tag);
        int n;
        logic [31:0] nb;
        #1;
        n = m_n();
        chk({tag, ".use"}, 64'(o_usingNUM), 64'(n));
        @(posedge clk);
        nb = m_busy;
        if (wb1v) nb[wb1a] = 1'b0;
        if (wb2v) nb[wb2a] = 1'b0;
        if (flush) begin
            if (m_v[1] && long_lat(m_o1)) nb[m_o1.rf_waddr] = 1'b0;
            if (m_v[0] && long_lat(m_o2)) nb[m_o2.rf_waddr] = 1'b0;
            m_v = 2'b00;
        end else if (!stall) begin
            m_o1 = a;
            m_o2 = b;
            m_v  = {n >= 1, n == 2};
            if (n >= 1 && long_lat(a)) nb[a.rf_waddr] = 1'b1;
            if (n == 2 && long_lat(b)) nb[b.rf_waddr] = 1'b1;
        end
        nb[0] = 1'b0;
        m_busy = nb;
        @(negedge clk);
        chk({tag, ".vld"}, 64'(o_is_valid), 64'(m_v));
        chk({tag, ".busy"}, 64'(o_busy), 64'(m_busy));
        if (m_v[1]) chk({tag, ".pc1"}, 64'(o_PC_set1), 64'(m_o1));
        if (m_v[0]) chk({tag, ".pc2"}, 64'(o_PC_set2), 64'(m_o2));
    endtask

    task automatic idle();
        iv = 2'b00; stall = 0; flush = 0; wb1v = 0; wb2v = 0;
    endtask

    initial begin
        int q[$];
        int r;
        rstn = 0; a = '0; b = '0; wb1a = 0; wb2a = 0;
        idle();
        m_busy = '0; m_v = 2'b00; m_o1 = '0; m_o2 = '0;
        #22;
        chk("rst.vld", 64'(o_is_valid), 64'd0);
        chk("rst.busy", 64'(o_busy), 64'd0);
        chk("rst.use", 64'(o_usingNUM), 64'd0);
        chk("rst.pc1", 64'(o_PC_set1), 64'd0);
        @(negedge clk);
        rstn = 1;

        // independent ALU pair
        a = mk(0, 1, 2, 3, 'h100); b = mk(0, 4, 2, 3, 'h104); iv = 2'b11;
        step("alu2");
        chk("alu2.order", 64'(o_PC_set2.pc), 64'h104);

        // load-use: B waits for writeback plus one bubble
        a = mk(1, 5, 0, 0, 'h108); b = mk(0, 6, 5, 1, 'h10c);
        step("ldu");
        chk("ldu.b5", 64'(o_busy[5]), 64'd1);
        a = b; iv = 2'b10;
        step("ldu.h0");
        step("ldu.h1");
        wb1v = 1; wb1a = 5;
        step("ldu.wb");
        wb1v = 0;
        step("ldu.go");
        chk("ldu.go.pc", 64'(o_PC_set1.pc), 64'h10c);

        // pairing restrictions
        iv = 2'b11;
        a = mk(1, 8, 1, 0, 'h200); b = mk(1, 9, 1, 0, 'h204);
        step("ldld");
        a = mk(3, 10, 1, 2, 'h208); b = mk(3, 11, 1, 2, 'h20c);
        step("divmul");
        a = mk(4, 0, 1, 2, 'h210); b = mk(0, 12, 1, 2, 'h214);
        step("bra");
        a = mk(0, 12, 1, 2, 'h218); b = mk(4, 0, 1, 2, 'h21c);
        step("brb");
        chk("brb.vld", 64'(o_is_valid), 64'd3);

        // stall holds the output register
        a = mk(0, 13, 1, 2, 'h300); b = mk(0, 14, 1, 2, 'h304);
        stall = 1;
        for (int i = 0; i < 3; i++) step("stall");
        chk("stall.hold", 64'(o_PC_set1.pc), 64'h218);
        stall = 0;
        step("unstall");

        // flush recovery of scoreboard bits
        iv = 2'b10; a = mk(1, 7, 1, 0, 'h400);
        step("ld7");
        iv = 2'b00; flush = 1;
        step("fl7");
        chk("fl7.b7", 64'(o_busy[7]), 64'd0);
        flush = 0; iv = 2'b10; a = mk(1, 3, 1, 0, 'h404);
        step("ld3");
        iv = 2'b00; flush = 1; stall = 1; wb2v = 1; wb2a = 3;
        step("fl3");
        chk("fl3.b3", 64'(o_busy[3]), 64'd0);
        idle();

        // random traffic
        for (int c = 0; c < 500; c++) begin
            r = $urandom_range(2);
            iv = (r == 0) ? 2'b00 : (r == 1) ? 2'b10 : 2'b11;
            a = mk($urandom_range(4), $urandom_range(7), $urandom_range(7),
                   $urandom_range(7), 4 * c);
            b = mk($urandom_range(4), $urandom_range(7), $urandom_range(7),
                   $urandom_range(7), 4 * c + 2);
            stall = ($urandom_range(7) == 0);
            flush = ($urandom_range(15) == 0);
            q.delete();
            for (int k = 1; k < 32; k++) if (m_busy[k]) q.push_back(k);
            wb1v = 0; wb2v = 0;
            if (q.size() > 0 && $urandom_range(2) == 0) begin
                wb1v = 1; wb1a = 5'(q[$urandom_range(q.size() - 1)]);
            end
            if (q.size() > 0 && $urandom_range(3) == 0) begin
                wb2v = 1; wb2a = 5'(q[$urandom_range(q.size() - 1)]);
            end
            step("rnd");
        end

        // drain the scoreboard, then async reset mid-cycle
        idle();
        for (int k = 1; k < 32; k++) begin
            wb1v = 1; wb1a = 5'(k);
            step("drain");
        end
        idle();
        iv = 2'b11;
        a = mk(1, 12, 1, 0, 'h500); b = mk(0, 13, 1, 2, 'h504);
        step("pre");
        chk("pre.vld", 64'(o_is_valid), 64'd3);
        chk("pre.b12", 64'(o_busy[12]), 64'd1);
        #2;
        rstn = 0;
        #1;
        chk("arst.vld", 64'(o_is_valid), 64'd0);
        chk("arst.busy", 64'(o_busy), 64'd0);
        chk("arst.pc1", 64'(o_PC_set1), 64'd0);
        chk("arst.pc2", 64'(o_PC_set2), 64'd0);
        m_busy = '0; m_v = 2'b00; m_o1 = '0; m_o2 = '0;
        @(negedge clk);
        rstn = 1;
        a = mk(0, 1, 2, 3, 'h600); b = mk(0, 4, 2, 3, 'h604);
        step("post");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1);
    end

endmodule
